// File: rtl/timing_pkg.sv
// Shared timing definitions for the tick divider and period meter.
// Holds the common interval width and the meter state encoding.
package timing_pkg;

  localparam int TICK_WIDTH = 28;

  typedef enum logic {
    IDLE,
    MEASURE
  } meter_state_e;

endpackage

// File: rtl/edge_toggle_detect.sv
// Turns each transition of a toggling input into a one-cycle tick.
// Ports: clk_i, reset_i (sync, high), en_i, toggle_i -> tick_o.
module edge_toggle_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic toggle_i,
  output logic tick_o
);

  logic prev_q;

  // The history register samples every cycle, so a transition seen
  // while disabled is absorbed and never produces a tick later.
  always_ff @(posedge clk_i) begin
    if (reset_i) prev_q <= 1'b0;
    else         prev_q <= toggle_i;
  end

  assign tick_o = en_i & (toggle_i ^ prev_q);

endmodule

// File: rtl/period_meter.sv
// Measures enabled-cycle spacing between transitions of toggleIn.
// Ports: clk, reset, en, toggleIn, timeoutLimit -> measured, valid, stable, timeout.
module period_meter
  import timing_pkg::*;
#(
  parameter int WIDTH = TICK_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             toggleIn,
  input  logic [WIDTH-1:0] timeoutLimit,
  output logic [WIDTH-1:0] measured,
  output logic             valid,
  output logic             stable,
  output logic             timeout
);

  meter_state_e     state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] meas_q;
  logic             valid_q;
  logic             stable_q;
  logic             tout_q;

  logic             tick;
  logic [WIDTH:0]   cnt_p1;
  logic [WIDTH-1:0] cnt_sat;
  logic             lim_hit;

  edge_toggle_detect u_edge (
    .clk_i    (clk),
    .reset_i  (reset),
    .en_i     (en),
    .toggle_i (toggleIn),
    .tick_o   (tick)
  );

  // One extra bit so an all-ones count is seen as overflow and clamped.
  assign cnt_p1  = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
  assign cnt_sat = cnt_p1[WIDTH] ? '1 : cnt_p1[WIDTH-1:0];
  assign lim_hit = (timeoutLimit != '0) &&
                   (cnt_p1 == {1'b0, timeoutLimit});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      meas_q   <= '0;
      valid_q  <= 1'b0;
      stable_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // First transition only arms; there is no reference edge yet.
          if (tick) state_q <= MEASURE;
        end
        MEASURE: begin
          if (tick) begin
            meas_q   <= cnt_sat;
            valid_q  <= 1'b1;
            stable_q <= (cnt_sat == meas_q);
            cnt_q    <= '0;
          end else if (en) begin
            if (lim_hit) begin
              tout_q   <= 1'b1;
              stable_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= IDLE;
            end else begin
              cnt_q <= cnt_sat;
            end
          end
        end
      endcase
    end
  end

  assign measured = meas_q;
  assign valid    = valid_q;
  assign stable   = stable_q;
  assign timeout  = tout_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed checks of period_meter against a
// timestamp-based reference model.
module tb_period_meter;
  import timing_pkg::*;

  localparam int W = TICK_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         toggleIn;
  logic [W-1:0] timeoutLimit;
  logic [W-1:0] measured;
  logic         valid;
  logic         stable;
  logic         timeout;

  period_meter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .toggleIn     (toggleIn),
    .timeoutLimit (timeoutLimit),
    .measured     (measured),
    .valid        (valid),
    .stable       (stable),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a free-running enabled-cycle clock and the
  // timestamp of the last accepted transition.
  bit           m_prev;
  bit           m_armed;
  longint       m_now;
  longint       m_last;
  logic [W-1:0] m_meas;
  bit           m_valid;
  bit           m_stable;
  bit           m_tout;

  task automatic model(bit r, bit e, bit t, longint lim);
    bit     tk;
    longint iv;
    longint maxv;
    maxv = (longint'(1) << W) - 1;
    if (r) begin
      m_prev = 0; m_armed = 0; m_now = 0; m_last = 0;
      m_meas = '0; m_valid = 0; m_stable = 0; m_tout = 0;
      return;
    end
    m_valid = 0;
    m_tout  = 0;
    tk = e && (t != m_prev);
    m_prev = t;
    if (e) m_now++;
    if (tk) begin
      if (m_armed) begin
        iv = m_now - m_last;
        if (iv > maxv) iv = maxv;
        m_stable = (W'(iv) == m_meas);
        m_meas   = W'(iv);
        m_valid  = 1;
      end
      m_armed = 1;
      m_last  = m_now;
    end else if (e && m_armed && lim != 0 && (m_now - m_last) == lim) begin
      m_tout   = 1;
      m_stable = 0;
      m_armed  = 0;
    end
  endtask

  bit     tg = 0;
  longint cur_lim = 0;

  task automatic cyc(bit r, bit e, bit t);
    @(negedge clk);
    reset        = r;
    en           = e;
    toggleIn     = t;
    timeoutLimit = W'(cur_lim);
    model(r, e, t, cur_lim);
    @(posedge clk);
    #1;
    check("measured", measured, m_meas);
    check("valid", W'(valid), W'(m_valid));
    check("stable", W'(stable), W'(m_stable));
    check("timeout", W'(timeout), W'(m_tout));
    check("excl", W'(valid & timeout), '0);
  endtask

  // k transitions, each n enabled cycles after the previous one.
  task automatic src(int n, int k);
    for (int j = 0; j < k; j++) begin
      for (int i = 1; i < n; i++) cyc(0, 1, tg);
      tg = ~tg;
      cyc(0, 1, tg);
    end
  endtask

  initial begin
    reset = 1; en = 0; toggleIn = 0; timeoutLimit = '0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("rst_meas", measured, '0);
    check("rst_valid", W'(valid), '0);

    // Interval 5: arm, then steady readings of 5.
    cur_lim = 0;
    src(5, 1);
    check("arm_novalid", W'(valid), '0);
    src(5, 3);
    check("int5_meas", measured, W'(5));
    check("int5_valid", W'(valid), W'(1));
    check("int5_stable", W'(stable), W'(1));

    // Interval 1: continuous valid.
    src(1, 6);
    check("int1_meas", measured, W'(1));
    check("int1_valid", W'(valid), W'(1));

    // Timeout 10 cycles after the last transition.
    cur_lim = 10;
    src(4, 3);
    check("pre_to_meas", measured, W'(4));
    for (int i = 0; i < 9; i++) cyc(0, 1, tg);
    check("to_early", W'(timeout), '0);
    cyc(0, 1, tg);
    check("to_pulse", W'(timeout), W'(1));
    check("to_stable", W'(stable), '0);
    check("to_meas", measured, W'(4));
    cyc(0, 1, tg);
    check("to_once", W'(timeout), '0);
    src(3, 1);
    check("rearm_novalid", W'(valid), '0);

    // Interval 6 with en low for 3 cycles in mid-interval.
    cur_lim = 0;
    src(6, 1);
    cyc(0, 1, tg);
    cyc(0, 1, tg);
    for (int i = 0; i < 3; i++) cyc(0, 0, tg);
    for (int i = 0; i < 3; i++) cyc(0, 1, tg);
    tg = ~tg;
    cyc(0, 1, tg);
    check("engap_meas", measured, W'(6));
    check("engap_valid", W'(valid), W'(1));

    // Tick coincides with timeout condition: tick wins.
    cur_lim = 7;
    src(7, 3);
    check("tie_meas", measured, W'(7));
    check("tie_valid", W'(valid), W'(1));
    check("tie_tout", W'(timeout), '0);

    // Reset 3 cycles into an interval of 8.
    cur_lim = 0;
    if (tg) begin
      tg = 0;
      cyc(0, 1, tg);
    end
    src(8, 2);
    for (int i = 0; i < 3; i++) cyc(0, 1, tg);
    cyc(1, 1, tg);
    check("rst2_meas", measured, '0);
    check("rst2_stable", W'(stable), '0);
    src(8, 1);
    check("rst2_arm", W'(valid), '0);
    src(8, 1);
    check("rst2_meas8", measured, W'(8));

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      int p;
      cur_lim = ($urandom % 3 == 0) ? 0 : longint'($urandom_range(20, 2));
      p = $urandom_range(25, 1);
      for (int i = 0; i < 60; i++) begin
        bit e;
        bit r;
        e = ($urandom % 6) != 0;
        r = ($urandom % 400) == 0;
        if (($urandom % 100) < p) tg = ~tg;
        cyc(r, e, tg);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
